// File: rtl/jarch_pkg.sv
// Shared opcode encoding and fixed write-back register addresses.
package jarch_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_JMP    = 4'd1,
        OP_CALL   = 4'd2,
        OP_RET    = 4'd3,
        OP_PUSH   = 4'd4,
        OP_POP    = 4'd5,
        OP_GSA    = 4'd6,
        OP_SWITCH = 4'd7,
        OP_SYS    = 4'd8,
        OP_KERNEL = 4'd9
    } op_e;

    localparam logic [7:0] KOFF_REG_ADDR = 8'h64;
    localparam logic [7:0] MODE_REG_ADDR = 8'h24;

endpackage

// File: rtl/callstack_mem.sv
// Call-stack storage: one shared address port, write on the falling clock edge, read combinational.
// Latency: writes land at the next falling edge; read data follows the address. No backpressure.
module callstack_mem #(
    parameter int DEPTH = 1024,
    parameter int W     = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(negedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/pc_callstack_unit.sv
// Program counter with hardware call stack, timer-interrupt takeover and stack-fault trap.
// Latency: all outputs registered, one cycle; init_flag=0 freezes every register (no backpressure otherwise).
module pc_callstack_unit
    import jarch_pkg::*;
#(
    parameter int               PC_W      = 16,
    parameter int               DATA_W    = 32,
    parameter int               DEPTH     = 1024,
    parameter int               WB_AW     = 8,
    parameter logic [WB_AW-1:0] KOFF_ADDR = KOFF_REG_ADDR,
    parameter logic [WB_AW-1:0] MODE_ADDR = MODE_REG_ADDR,
    localparam int              SW        = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              init_flag,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] result,
    input  logic [PC_W-1:0]   r_k,
    input  logic [PC_W-1:0]   sys_int_pos,
    input  logic [PC_W-1:0]   int_pos,
    input  logic [PC_W-1:0]   fault_pos,
    input  logic              timer_int,
    output logic [PC_W-1:0]   PC_pos,
    output logic              PRG_write_flag,
    output logic [WB_AW-1:0]  PRG_write_addr,
    output logic [DATA_W-1:0] PRG_write_data,
    output logic [SW:0]       stack_level,
    output logic              int_pending,
    output logic              fault
);

    localparam int            LW   = SW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [SW:0]       level_q, level_d;
    logic              pend_q, pend_d;
    logic              fault_q, fault_d;
    logic              wf_q, wf_d;
    logic [WB_AW-1:0]  wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;

    op_e             op_c;
    logic            is_push, is_pop, is_branch, trap_fault, trap_int;
    logic            mem_we;
    logic [SW-1:0]   mem_addr;
    logic [PC_W-1:0] mem_wdata, mem_rdata, seq_pc, tgt_pc;

    assign op_c       = op_e'(op);
    assign is_push    = (op_c == OP_CALL) || (op_c == OP_PUSH);
    assign is_pop     = (op_c == OP_RET)  || (op_c == OP_POP);
    assign is_branch  = (op_c == OP_JMP)  || (op_c == OP_CALL) || (op_c == OP_RET);
    assign trap_fault = (is_push && level_q == FULL) || (is_pop && level_q == '0);
    assign trap_int   = is_branch && (pend_q || timer_int);
    assign seq_pc     = pc_q + PC_W'(1);
    assign tgt_pc     = result[PC_W-1:0] + r_k;

    // Single port: pushes address the free slot, pops the top entry.
    assign mem_addr  = is_push ? level_q[SW-1:0] : level_q[SW-1:0] - SW'(1);
    assign mem_wdata = (op_c == OP_CALL) ? seq_pc : tgt_pc;

    always_comb begin
        pc_d    = pc_q;
        level_d = level_q;
        pend_d  = pend_q;
        fault_d = fault_q;
        wf_d    = wf_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        mem_we  = 1'b0;
        if (init_flag) begin
            wf_d   = 1'b0;
            pend_d = pend_q | timer_int;
            pc_d   = seq_pc;
            if (trap_fault) begin
                fault_d = 1'b1;
                pc_d    = fault_pos;
            end else if (trap_int) begin
                pc_d   = int_pos;
                wf_d   = 1'b1;
                wa_d   = KOFF_ADDR;
                wd_d   = '0;
                pend_d = 1'b0;
            end else begin
                case (op_c)
                    OP_JMP:  pc_d = result[PC_W-1:0];
                    OP_CALL: begin
                        mem_we  = !reset;
                        level_d = level_q + LW'(1);
                        pc_d    = tgt_pc;
                    end
                    OP_RET: begin
                        level_d = level_q - LW'(1);
                        pc_d    = mem_rdata;
                    end
                    OP_PUSH: begin
                        mem_we  = !reset;
                        level_d = level_q + LW'(1);
                    end
                    OP_POP: begin
                        level_d = level_q - LW'(1);
                        wf_d    = 1'b1;
                        wa_d    = result[WB_AW-1:0];
                        wd_d    = DATA_W'(mem_rdata);
                    end
                    OP_GSA: begin
                        wf_d = 1'b1;
                        wa_d = result[WB_AW-1:0];
                        wd_d = DATA_W'(level_q);
                    end
                    OP_SWITCH: begin
                        pc_d = tgt_pc;
                        wf_d = 1'b1;
                        wa_d = MODE_ADDR;
                        wd_d = DATA_W'(result[PC_W]);
                    end
                    OP_SYS: begin
                        pc_d = sys_int_pos;
                        wf_d = 1'b1;
                        wa_d = KOFF_ADDR;
                        wd_d = '0;
                    end
                    OP_KERNEL: begin
                        pc_d = result[2*PC_W-1:PC_W];
                        wf_d = 1'b1;
                        wa_d = KOFF_ADDR;
                        wd_d = DATA_W'(result[PC_W-1:0]);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            pc_q    <= '0;
            level_q <= '0;
            pend_q  <= 1'b0;
            fault_q <= 1'b0;
            wf_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            pc_q    <= pc_d;
            level_q <= level_d;
            pend_q  <= pend_d;
            fault_q <= fault_d;
            wf_q    <= wf_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end

    callstack_mem #(
        .DEPTH (DEPTH),
        .W     (PC_W),
        .AW    (SW)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign PC_pos         = pc_q;
    assign stack_level    = level_q;
    assign int_pending    = pend_q;
    assign fault          = fault_q;
    assign PRG_write_flag = wf_q;
    assign PRG_write_addr = wa_q;
    assign PRG_write_data = wd_q;

endmodule
